// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: state encodings and
// default geometry used by decode and writeback.
package regfile_mp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks the array one entry per cycle after reset or on a
// software re-clear request, then raises ready.
module regfile_clr_seq
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              run,
  output logic              ready,
  output logic [ADDR_W-1:0] clr_busy_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  state_e            state_r, state_nxt_s;
  logic [ADDR_W-1:0] ptr_r, ptr_nxt_s;
  logic              ready_r, ready_nxt_s;

  // State, pointer and ready registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  // Next-state logic; clr_req is only honoured once the array is in service
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    ready_nxt_s = ready_r;
    case (state_r)
      ST_CLEAR: begin
        if (ptr_r == LAST_PTR) begin
          state_nxt_s = ST_RUN;
          ptr_nxt_s   = '0;
          ready_nxt_s = 1'b1;
        end else begin
          ptr_nxt_s   = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          ready_nxt_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_nxt_s = ST_CLEAR;
          ptr_nxt_s   = '0;
          ready_nxt_s = 1'b0;
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        ptr_nxt_s   = '0;
        ready_nxt_s = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    clr_we   = 1'b0;
    run      = 1'b0;
    clr_addr = ptr_r;
    if (state_r == ST_CLEAR) begin
      clr_we = 1'b1;
    end else begin
      run = 1'b1;
    end
  end

  assign ready        = ready_r;
  assign clr_busy_cnt = ptr_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional zero register,
// optional write-to-read bypass and a sequenced (RAM-friendly) clear.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic                  clr_req,
  output logic                  ready,
  output logic [ADDR_W-1:0]     clr_busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              run_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wd_s;

  regfile_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_req     (clr_req),
    .clr_we      (clr_we_s),
    .clr_addr    (clr_addr_s),
    .run         (run_s),
    .ready       (ready),
    .clr_busy_cnt(clr_busy_cnt)
  );

  // Write port mux: clear sequencer has priority; nothing is written in a reset cycle
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = wa;
    mem_wd_s   = wd;
    if (!rst_n) begin
      mem_we_s = 1'b0;
    end else if (clr_we_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = clr_addr_s;
      mem_wd_s   = '0;
    end else if (run_s && we && !((ZERO_REG != 0) && (wa == '0))) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage; intentionally no reset so it maps onto distributed RAM
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_addr_s] <= mem_wd_s;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rd_s;

    assign ra_s = ra[i*ADDR_W +: ADDR_W];

    // Read mux: zero register beats bypass, which beats the array
    always_comb begin
      rd_s = '0;
      if (!run_s) begin
        rd_s = '0;
      end else if ((ZERO_REG != 0) && (ra_s == '0)) begin
        rd_s = '0;
      end else if ((BYPASS != 0) && we && (ra_s == wa)) begin
        rd_s = wd;
      end else begin
        rd_s = mem[ra_s];
      end
    end

    assign rd[i*DATA_W +: DATA_W] = rd_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, no-bypass and 4-port/64-bit/16-entry
// instances checked against a queue of expected values.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default and BYPASS=0 instances share stimulus
  logic        rst_n, we, clr_req;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd_a, rd_b;
  logic        ready_a, ready_b;
  logic [4:0]  cnt_a, cnt_b;

  // NRD=4, DATA_W=64, ADDR_W=4 instance
  logic         c_rst_n, c_we, c_clr_req;
  logic [3:0]   c_wa;
  logic [63:0]  c_wd;
  logic [15:0]  c_ra;
  logic [255:0] c_rd;
  logic         c_ready;
  logic [3:0]   c_cnt;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
    .clr_req(clr_req), .ready(ready_a), .clr_busy_cnt(cnt_a)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
    .clr_req(clr_req), .ready(ready_b), .clr_busy_cnt(cnt_b)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NRD(4)) dut_c (
    .clk(clk), .rst_n(c_rst_n), .we(c_we), .wa(c_wa), .wd(c_wd), .ra(c_ra), .rd(c_rd),
    .clr_req(c_clr_req), .ready(c_ready), .clr_busy_cnt(c_cnt)
  );

  logic [63:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] e);
    exp_q.push_back(e);
  endtask

  task automatic ck(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h but scoreboard is empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; clr_req = 1'b0; wa = 5'd0; wd = 32'd0; ra = 10'd0;
    c_rst_n = 1'b0; c_we = 1'b0; c_clr_req = 1'b0; c_wa = 4'd0; c_wd = 64'd0; c_ra = 16'd0;

    // Reset held for 3 cycles
    repeat (3) tick;
    push(64'd0); ck("rst_ready_a", {63'd0, ready_a});
    push(64'd0); ck("rst_cnt_a", {59'd0, cnt_a});

    // Release; hammer writes to entry 3 during the clear
    rst_n = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h1; ra = {5'd3, 5'd3};
    for (int i = 0; i < 32; i++) begin
      #2;
      push(64'(i)); ck("clr_cnt_a", {59'd0, cnt_a});
      push(64'(i)); ck("clr_cnt_b", {59'd0, cnt_b});
      push(64'd0);  ck("clr_ready_a", {63'd0, ready_a});
      push(64'd0);  ck("clr_rd_a", rd_a);
      push(64'd0);  ck("clr_rd_b", rd_b);
      tick;
    end
    push(64'd1); ck("ready_a", {63'd0, ready_a});
    push(64'd1); ck("ready_b", {63'd0, ready_b});
    we = 1'b0; #2;
    push(64'd0); ck("wr_ignored_clear", rd_a);

    // Basic write/read
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; tick;
    wa = 5'd31; wd = 32'h12345678; tick;
    we = 1'b0; ra = {5'd31, 5'd5}; #2;
    push({32'h12345678, 32'hDEADBEEF}); ck("rd_basic_a", rd_a);
    push({32'h12345678, 32'hDEADBEEF}); ck("rd_basic_b", rd_b);

    // Zero register: beats bypass and discards writes
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = {5'd5, 5'd0}; #2;
    push(64'd0); ck("zero_vs_bypass", {32'd0, rd_a[31:0]});
    tick; we = 1'b0; #2;
    push({32'hDEADBEEF, 32'd0}); ck("zero_after_a", rd_a);
    push({32'hDEADBEEF, 32'd0}); ck("zero_after_b", rd_b);

    // Bypass vs no bypass
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd5, 5'd7}; #2;
    push(64'hA5A5A5A5); ck("bypass_a", {32'd0, rd_a[31:0]});
    push(64'd0);        ck("nobypass_b", {32'd0, rd_b[31:0]});
    tick; we = 1'b0; #2;
    push(64'hA5A5A5A5); ck("nobypass_b_next", {32'd0, rd_b[31:0]});

    // Fill 1..31 with index
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i); tick;
    end
    we = 1'b0; ra = {5'd31, 5'd9}; #2;
    push({32'd31, 32'd9}); ck("fill_a", rd_a);

    // Re-clear with a same-cycle write to entry 9
    clr_req = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h99; #2;
    push(64'h99); ck("bypass_at_clr", {32'd0, rd_a[31:0]});
    tick; clr_req = 1'b0; we = 1'b0; #2;
    push(64'd0); ck("reclr_ready_drop", {63'd0, ready_a});
    for (int i = 0; i < 32; i++) begin
      push(64'(i)); ck("reclr_cnt", {59'd0, cnt_a});
      clr_req = (i == 10);
      tick; #2;
    end
    clr_req = 1'b0;
    push(64'd1); ck("reclr_ready", {63'd0, ready_a});
    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)}; #1;
      push(64'd0); ck("reclr_zero", rd_a);
    end

    // Reset in the middle of a clear
    clr_req = 1'b1; tick; clr_req = 1'b0;
    repeat (17) tick;
    #2;
    push(64'd17); ck("midclr_cnt17", {59'd0, cnt_a});
    rst_n = 1'b0; tick; rst_n = 1'b1; #2;
    push(64'd0); ck("midclr_cnt0", {59'd0, cnt_a});
    for (int i = 0; i < 32; i++) begin
      push(64'(i)); ck("midclr_cnt", {59'd0, cnt_a});
      push(64'd0);  ck("midclr_ready", {63'd0, ready_a});
      tick; #2;
    end
    push(64'd1); ck("midclr_ready_up", {63'd0, ready_a});

    // 4-port, 64-bit, 16-entry instance
    c_rst_n = 1'b1; #2;
    for (int i = 0; i < 16; i++) begin
      push(64'(i)); ck("c_clr_cnt", {60'd0, c_cnt});
      push(64'd0);  ck("c_clr_ready", {63'd0, c_ready});
      tick; #2;
    end
    push(64'd1); ck("c_ready", {63'd0, c_ready});
    for (int i = 0; i < 16; i++) begin
      c_we = 1'b1; c_wa = 4'(i); c_wd = 64'hC0DE_0000_0000_0000 | 64'(i); tick;
    end
    c_we = 1'b0; c_ra = {4'd15, 4'd0, 4'd8, 4'd2}; #2;
    push(64'hC0DE_0000_0000_0002); ck("c_rd0", c_rd[63:0]);
    push(64'hC0DE_0000_0000_0008); ck("c_rd1", c_rd[127:64]);
    push(64'd0);                   ck("c_rd2_zero", c_rd[191:128]);
    push(64'hC0DE_0000_0000_000F); ck("c_rd3", c_rd[255:192]);
    c_we = 1'b1; c_wa = 4'd8; c_wd = 64'h0123_4567_89AB_CDEF; #2;
    push(64'h0123_4567_89AB_CDEF); ck("c_bypass1", c_rd[127:64]);
    push(64'hC0DE_0000_0000_0002); ck("c_nobyp0", c_rd[63:0]);
    tick; c_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
